// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receiver files: the receiver state
//   encoding and the PARITY parameter values.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//   Two-flop synchroniser for the asynchronous rx pin, plus the bit voter.
//   Build option UART_RX_MAJORITY_EN: bit_val is the majority of rs over the
//   current and the two previous s_tick samples; otherwise bit_val is rs.
// Ports
//   clk     in   clock
//   reset   in   asynchronous, active-high; synchroniser resets to idle (1)
//   rx      in   raw serial line
//   s_tick  in   oversample enable (present only with UART_RX_MAJORITY_EN)
//   rs      out  synchronised line, 2 clk behind rx
//   bit_val out  voted bit value for the receiver FSM
// ---------------------------------------------------------------------------
module uart_rx_sampler (
    input  logic clk,
    input  logic reset,
    input  logic rx,
`ifdef UART_RX_MAJORITY_EN
    input  logic s_tick,
`endif
    output logic rs,
    output logic bit_val
);

    logic sync1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rs    <= 1'b1;
        end else begin
            sync1 <= rx;
            rs    <= sync1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // hist holds rs at the two previous ticks, so on the tick at M+1 the
    // vote covers ticks M-1, M and M+1.
    logic [1:0] hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '1;
        end else if (s_tick) begin
            hist <= {hist[0], rs};
        end
    end

    assign bit_val = (hist[1] & hist[0]) | (hist[1] & rs) | (hist[0] & rs);
`else
    assign bit_val = rs;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver: DBIT data bits (LSB first), optional
//   even/odd parity, SB_TICK-tick stop period, false-start rejection,
//   parity/framing/overrun/break reporting and a valid/ready holding register.
//   Build option UART_RX_MAJORITY_EN: 3-sample majority vote, decisions one
//   tick later.
// Ports
//   clk          in   clock
//   reset        in   asynchronous, active-high
//   rx           in   serial line, idles high
//   s_tick       in   oversample enable pulse
//   rx_ready     in   consumer accepts the held word
//   dout         out  held data word
//   rx_valid     out  held word valid until accepted
//   parity_err   out  parity mismatch of the held word
//   frame_err    out  stop bit was 0 for the held word
//   rx_done_tick out  one-clk pulse per completed frame
//   overrun_err  out  one-clk pulse: frame completed while a word was held
//   break_det    out  break in progress, cleared when rx returns high
// ---------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16,
    parameter int PARITY     = PARITY_NONE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    input  logic            rx_ready,
    output logic [DBIT-1:0] dout,
    output logic            rx_valid,
    output logic            parity_err,
    output logic            frame_err,
    output logic            rx_done_tick,
    output logic            overrun_err,
    output logic            break_det
);

    localparam int S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int S_W   = $clog2(S_MAX);
    localparam int N_W   = $clog2(DBIT);
    localparam int M     = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int DEC_LAG = 1;
`else
    localparam int DEC_LAG = 0;
`endif
    localparam logic [S_W-1:0] S_DEC      = S_W'(M + DEC_LAG);
    localparam logic [S_W-1:0] S_LAST     = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_DEC = S_W'(SB_TICK - M + DEC_LAG);
    localparam logic [N_W-1:0] N_LAST     = N_W'(DBIT - 1);

    logic rs;
    logic bit_val;

    uart_rx_sampler u_sampler (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
`ifdef UART_RX_MAJORITY_EN
        .s_tick  (s_tick),
`endif
        .rs      (rs),
        .bit_val (bit_val)
    );

    rx_state_t       state_reg, state_next;
    logic [S_W-1:0]  s_reg, s_next;
    logic [N_W-1:0]  n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            perr_reg, perr_next;
    logic            done;
    logic            ferr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            perr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            perr_reg  <= perr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        perr_next  = perr_reg;
        done       = 1'b0;
        ferr       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!rs) begin
                    state_next = ST_START;
                    s_next     = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_reg == S_DEC && bit_val) begin
                        state_next = ST_IDLE;   // line back high mid start bit
                    end else if (s_reg == S_LAST) begin
                        state_next = ST_DATA;
                        s_next     = '0;
                        n_next     = '0;
                        perr_next  = 1'b0;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_reg == S_DEC) begin
                        b_next = {bit_val, b_reg[DBIT-1:1]};
                    end
                    if (s_reg == S_LAST) begin
                        s_next = '0;
                        if (n_reg == N_LAST) begin
                            state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_next = n_reg + N_W'(1);
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_reg == S_DEC) begin
                        perr_next = bit_val ^ (^b_reg) ^ (PARITY == PARITY_ODD);
                    end
                    if (s_reg == S_LAST) begin
                        state_next = ST_STOP;
                        s_next     = '0;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            ST_STOP: begin
                // The frame completes at the stop sample; the remainder of the
                // stop period is spent in IDLE.
                if (s_tick) begin
                    if (s_reg == S_STOP_DEC) begin
                        done       = 1'b1;
                        ferr       = ~bit_val;
                        state_next = (!bit_val && b_reg == '0) ? ST_BREAK : ST_IDLE;
                        s_next     = '0;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            ST_BREAK: begin
                if (rs) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout         <= '0;
            rx_valid     <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            rx_done_tick <= done;
            overrun_err  <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    dout       <= b_reg;
                    parity_err <= (PARITY != PARITY_NONE) && perr_reg;
                    frame_err  <= ferr;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign break_det = (state_reg == ST_BREAK);

endmodule
